// File: rtl/dds_sweep_ctrl_if.sv
// Config, control and phase-output signals of the DDS sweep controller.
// The controller uses the slave modport; a stimulus/driver side uses master.
interface dds_sweep_ctrl_if #(
   parameter int PHASE_DW = 16,
   parameter int STEP_DW  = 16,
   parameter int DWELL_DW = 8
);
   logic [PHASE_DW-1:0] s_axis_cfg_start_freq;
   logic [PHASE_DW-1:0] s_axis_cfg_step;
   logic [STEP_DW-1:0]  s_axis_cfg_num_steps;
   logic [DWELL_DW-1:0] s_axis_cfg_dwell;
   logic                s_axis_cfg_loop;
   logic                s_axis_cfg_tvalid;
   logic                s_axis_cfg_tready;
   logic                start;
   logic                abort;
   logic [PHASE_DW-1:0] m_axis_phase_tdata;
   logic                m_axis_phase_tvalid;
   logic                busy;
   logic                done;
   logic                cfg_loaded;

   modport slave (
      input  s_axis_cfg_start_freq, s_axis_cfg_step, s_axis_cfg_num_steps,
      input  s_axis_cfg_dwell, s_axis_cfg_loop, s_axis_cfg_tvalid,
      input  start, abort,
      output s_axis_cfg_tready, m_axis_phase_tdata, m_axis_phase_tvalid,
      output busy, done, cfg_loaded
   );

   modport master (
      output s_axis_cfg_start_freq, s_axis_cfg_step, s_axis_cfg_num_steps,
      output s_axis_cfg_dwell, s_axis_cfg_loop, s_axis_cfg_tvalid,
      output start, abort,
      input  s_axis_cfg_tready, m_axis_phase_tdata, m_axis_phase_tvalid,
      input  busy, done, cfg_loaded
   );
endinterface

// File: rtl/dds_sweep_ctrl.sv
// Stepped-frequency sweep generator feeding a DDS phase input.
// Define DDS_SWEEP_LOOP_EN to honour the config loop bit; otherwise sweeps are one-shot.
module dds_sweep_ctrl #(
   parameter int PHASE_DW = 16,
   parameter int STEP_DW  = 16,
   parameter int DWELL_DW = 8
) (
   input logic              clk,
   input logic              reset_n,
   dds_sweep_ctrl_if.slave  bus
);

`ifdef DDS_SWEEP_LOOP_EN
   localparam logic LOOP_EN = 1'b1;
`else
   localparam logic LOOP_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_next;

   logic [PHASE_DW-1:0] r_start_freq;
   logic [PHASE_DW-1:0] r_step;
   logic [STEP_DW-1:0]  r_num_steps;
   logic [DWELL_DW-1:0] r_dwell;
   logic                r_loop;
   logic                r_cfg_loaded;

   logic [PHASE_DW-1:0] r_acc;
   logic [PHASE_DW-1:0] r_freq;
   logic [DWELL_DW-1:0] r_dcnt;
   logic [STEP_DW-1:0]  r_scnt;

   logic                r_tvalid;
   logic                r_busy;
   logic                r_done;
   logic                r_tready;

   logic                w_hs;
   logic                w_init;
   logic                w_adv;
   logic                w_last;
   logic                w_loop;
   logic [PHASE_DW-1:0] w_start_freq;

   assign w_last       = (r_dcnt == r_dwell) && (r_scnt == r_num_steps);
   assign w_loop       = r_loop & LOOP_EN;
   // A config accepted in the same cycle as start must seed the sweep directly.
   assign w_start_freq = w_hs ? bus.s_axis_cfg_start_freq : r_start_freq;

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state and datapath control strobes.
   always_comb begin
      w_next = r_state;
      w_hs   = 1'b0;
      w_init = 1'b0;
      w_adv  = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_hs = bus.s_axis_cfg_tvalid & r_tready;
            if (bus.start && !bus.abort && (r_cfg_loaded || w_hs)) begin
               w_next = S_RUN;
               w_init = 1'b1;
            end else begin
               w_next = S_IDLE;
            end
         end
         S_RUN: begin
            if (bus.abort) begin
               w_next = S_IDLE;
            end else if (w_last) begin
               if (w_loop) begin
                  w_next = S_RUN;
                  w_init = 1'b1;
               end else begin
                  w_next = S_DONE;
               end
            end else begin
               w_next = S_RUN;
               w_adv  = 1'b1;
            end
         end
         S_DONE: begin
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // Shadow config registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_start_freq <= {PHASE_DW{1'b0}};
         r_step       <= {PHASE_DW{1'b0}};
         r_num_steps  <= {STEP_DW{1'b0}};
         r_dwell      <= {DWELL_DW{1'b0}};
         r_loop       <= 1'b0;
         r_cfg_loaded <= 1'b0;
      end else if (w_hs) begin
         r_start_freq <= bus.s_axis_cfg_start_freq;
         r_step       <= bus.s_axis_cfg_step;
         r_num_steps  <= bus.s_axis_cfg_num_steps;
         r_dwell      <= bus.s_axis_cfg_dwell;
         r_loop       <= bus.s_axis_cfg_loop;
         r_cfg_loaded <= 1'b1;
      end
   end

   // Phase accumulator, current frequency and dwell/step counters.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_acc  <= {PHASE_DW{1'b0}};
         r_freq <= {PHASE_DW{1'b0}};
         r_dcnt <= {DWELL_DW{1'b0}};
         r_scnt <= {STEP_DW{1'b0}};
      end else if (w_init) begin
         r_acc  <= {PHASE_DW{1'b0}};
         r_freq <= w_start_freq;
         r_dcnt <= {DWELL_DW{1'b0}};
         r_scnt <= {STEP_DW{1'b0}};
      end else if (w_adv) begin
         // r_acc is the sample on the bus now; the add uses the pre-step frequency.
         r_acc <= r_acc + r_freq;
         if (r_dcnt == r_dwell) begin
            r_dcnt <= {DWELL_DW{1'b0}};
            r_scnt <= r_scnt + STEP_DW'(1);
            r_freq <= r_freq + r_step;
         end else begin
            r_dcnt <= r_dcnt + DWELL_DW'(1);
         end
      end
   end

   // Status outputs follow the state being entered.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_tvalid <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_tready <= 1'b0;
      end else begin
         r_tvalid <= (w_next == S_RUN);
         r_busy   <= (w_next == S_RUN);
         r_done   <= (w_next == S_DONE);
         r_tready <= (w_next == S_IDLE);
      end
   end

   assign bus.s_axis_cfg_tready   = r_tready;
   assign bus.m_axis_phase_tdata  = r_acc;
   assign bus.m_axis_phase_tvalid = r_tvalid;
   assign bus.busy                = r_busy;
   assign bus.done                = r_done;
   assign bus.cfg_loaded          = r_cfg_loaded;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed and randomized checks of dds_sweep_ctrl against a sample-list model.
// Loop expectations follow DDS_SWEEP_LOOP_EN as seen by this compilation.
module tb_dds_sweep_ctrl;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   errors = 0;
   int   checks = 0;
   logic [15:0] exp_q[$];

   always #5 clk = ~clk;

   dds_sweep_ctrl_if #(.PHASE_DW(16), .STEP_DW(16), .DWELL_DW(8)) bus ();

   dds_sweep_ctrl #(.PHASE_DW(16), .STEP_DW(16), .DWELL_DW(8)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected phase sequence: each segment holds one frequency for dwell+1 samples.
   task automatic build(input logic [15:0] sf, input logic [15:0] st, input int ns, input int dw);
      logic [15:0] acc;
      logic [15:0] f;
      exp_q.delete();
      acc = 16'h0000;
      f   = sf;
      for (int s = 0; s <= ns; s++) begin
         for (int d = 0; d <= dw; d++) begin
            exp_q.push_back(acc);
            acc = acc + f;
         end
         f = f + st;
      end
   endtask

   task automatic drive_cfg(input logic [15:0] sf, input logic [15:0] st, input int ns,
                            input int dw, input logic lp);
      bus.s_axis_cfg_start_freq = sf;
      bus.s_axis_cfg_step       = st;
      bus.s_axis_cfg_num_steps  = 16'(ns);
      bus.s_axis_cfg_dwell      = 8'(dw);
      bus.s_axis_cfg_loop       = lp;
   endtask

   task automatic load_cfg(input logic [15:0] sf, input logic [15:0] st, input int ns,
                           input int dw, input logic lp);
      logic ok;
      ok = 1'b0;
      drive_cfg(sf, st, ns, dw, lp);
      bus.s_axis_cfg_tvalid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (bus.s_axis_cfg_tready === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      check("cfg_handshake_wait", 32'(ok), 32'd1);
      @(posedge clk);
      #1 bus.s_axis_cfg_tvalid = 1'b0;
   endtask

   task automatic pulse_start;
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
   endtask

   task automatic expect_samples(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check({tag, "_tvalid"}, 32'(bus.m_axis_phase_tvalid), 32'd1);
         check({tag, "_tdata"}, 32'(bus.m_axis_phase_tdata), 32'(exp_q[i]));
         check({tag, "_busy"}, 32'(bus.busy), 32'd1);
         check({tag, "_done"}, 32'(bus.done), 32'd0);
      end
   endtask

   task automatic expect_done(input string tag);
      @(negedge clk);
      check({tag, "_done_tvalid"}, 32'(bus.m_axis_phase_tvalid), 32'd0);
      check({tag, "_done_pulse"}, 32'(bus.done), 32'd1);
      check({tag, "_done_busy"}, 32'(bus.busy), 32'd0);
      check({tag, "_done_tready"}, 32'(bus.s_axis_cfg_tready), 32'd0);
      @(negedge clk);
      check({tag, "_post_done"}, 32'(bus.done), 32'd0);
      check({tag, "_post_tready"}, 32'(bus.s_axis_cfg_tready), 32'd1);
      check({tag, "_post_tvalid"}, 32'(bus.m_axis_phase_tvalid), 32'd0);
   endtask

   task automatic expect_quiet(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check({tag, "_tvalid"}, 32'(bus.m_axis_phase_tvalid), 32'd0);
         check({tag, "_busy"}, 32'(bus.busy), 32'd0);
         check({tag, "_done"}, 32'(bus.done), 32'd0);
      end
   endtask

   task automatic abort_and_check(input string tag);
      bus.abort = 1'b1;
      @(posedge clk);
      #1 bus.abort = 1'b0;
      @(negedge clk);
      check({tag, "_tvalid"}, 32'(bus.m_axis_phase_tvalid), 32'd0);
      check({tag, "_done"}, 32'(bus.done), 32'd0);
      check({tag, "_busy"}, 32'(bus.busy), 32'd0);
      check({tag, "_tready"}, 32'(bus.s_axis_cfg_tready), 32'd1);
      @(negedge clk);
      check({tag, "_done_late"}, 32'(bus.done), 32'd0);
   endtask

   initial begin
      logic [15:0] rsf;
      logic [15:0] rst;
      int          rns;
      int          rdw;
      int          n;

      drive_cfg(16'h0000, 16'h0000, 0, 0, 1'b0);
      bus.s_axis_cfg_tvalid = 1'b0;
      bus.start             = 1'b0;
      bus.abort             = 1'b0;

      // Reset state.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_tready", 32'(bus.s_axis_cfg_tready), 32'd0);
      check("rst_tvalid", 32'(bus.m_axis_phase_tvalid), 32'd0);
      check("rst_tdata", 32'(bus.m_axis_phase_tdata), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_cfg_loaded", 32'(bus.cfg_loaded), 32'd0);
      @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Start before any config is ignored.
      pulse_start();
      expect_quiet("nocfg", 4);
      check("nocfg_loaded", 32'(bus.cfg_loaded), 32'd0);

      // Basic sweep.
      build(16'h0100, 16'h0010, 2, 1);
      load_cfg(16'h0100, 16'h0010, 2, 1, 1'b0);
      check("basic_cfg_loaded", 32'(bus.cfg_loaded), 32'd1);
      pulse_start();
      expect_samples("basic", exp_q.size());
      expect_done("basic");

      // Loop bit set.
      load_cfg(16'h0100, 16'h0010, 2, 1, 1'b1);
      pulse_start();
`ifdef DDS_SWEEP_LOOP_EN
      exp_q.push_back(16'h0000);
      exp_q.push_back(16'h0100);
      expect_samples("loop", exp_q.size());
      abort_and_check("loop_abort");
`else
      expect_samples("loop", exp_q.size());
      expect_done("loop");
`endif

      // Abort on the third sample.
      build(16'h0100, 16'h0010, 2, 1);
      load_cfg(16'h0100, 16'h0010, 2, 1, 1'b0);
      pulse_start();
      expect_samples("abort", 3);
      abort_and_check("abort");

      // Wrap with negative step.
      build(16'hF000, 16'hF000, 1, 1);
      load_cfg(16'hF000, 16'hF000, 1, 1, 1'b0);
      pulse_start();
      expect_samples("wrap", exp_q.size());
      expect_done("wrap");

      // Single-sample sweep.
      build(16'h5555, 16'h1111, 0, 0);
      load_cfg(16'h5555, 16'h1111, 0, 0, 1'b0);
      pulse_start();
      expect_samples("single", exp_q.size());
      expect_done("single");

      // Config offered during RUN is refused; the old config restarts unchanged.
      build(16'h0040, 16'h0008, 1, 3);
      load_cfg(16'h0040, 16'h0008, 1, 3, 1'b0);
      pulse_start();
      for (int i = 0; i < exp_q.size(); i++) begin
         @(negedge clk);
         check("runcfg_tdata", 32'(bus.m_axis_phase_tdata), 32'(exp_q[i]));
         check("runcfg_tvalid", 32'(bus.m_axis_phase_tvalid), 32'd1);
         if (i == 1) begin
            drive_cfg(16'h7777, 16'h0001, 0, 0, 1'b0);
            bus.s_axis_cfg_tvalid = 1'b1;
         end
         if (i >= 2 && i <= 4) begin
            check("runcfg_tready", 32'(bus.s_axis_cfg_tready), 32'd0);
         end
         if (i == 4) begin
            bus.s_axis_cfg_tvalid = 1'b0;
         end
      end
      expect_done("runcfg");
      pulse_start();
      expect_samples("restart", exp_q.size());
      expect_done("restart");

      // Start together with a config handshake uses the new config.
      build(16'h1234, 16'h0101, 1, 0);
      drive_cfg(16'h1234, 16'h0101, 1, 0, 1'b0);
      bus.s_axis_cfg_tvalid = 1'b1;
      bus.start             = 1'b1;
      @(posedge clk);
      #1;
      bus.s_axis_cfg_tvalid = 1'b0;
      bus.start             = 1'b0;
      expect_samples("samecyc", exp_q.size());
      expect_done("samecyc");

      // Start and abort together: no sweep, but the config is taken.
      build(16'h0777, 16'h0001, 0, 2);
      drive_cfg(16'h0777, 16'h0001, 0, 2, 1'b0);
      bus.s_axis_cfg_tvalid = 1'b1;
      bus.start             = 1'b1;
      bus.abort             = 1'b1;
      @(posedge clk);
      #1;
      bus.s_axis_cfg_tvalid = 1'b0;
      bus.start             = 1'b0;
      bus.abort             = 1'b0;
      expect_quiet("stab", 3);
      pulse_start();
      expect_samples("stab_cfg", exp_q.size());
      expect_done("stab_cfg");

      // Randomized configurations.
      for (int k = 0; k < 6; k++) begin
         rsf = 16'($urandom);
         rst = 16'($urandom);
         rns = int'($urandom_range(0, 3));
         rdw = int'($urandom_range(0, 3));
         build(rsf, rst, rns, rdw);
         load_cfg(rsf, rst, rns, rdw, 1'b0);
         pulse_start();
         n = exp_q.size();
         expect_samples("rand", n);
         expect_done("rand");
      end

      // Asynchronous reset mid-sweep.
      build(16'h0100, 16'h0010, 2, 1);
      load_cfg(16'h0100, 16'h0010, 2, 1, 1'b0);
      pulse_start();
      expect_samples("prereset", 2);
      #2 reset_n = 1'b0;
      #1;
      check("arst_tvalid", 32'(bus.m_axis_phase_tvalid), 32'd0);
      check("arst_tdata", 32'(bus.m_axis_phase_tdata), 32'd0);
      check("arst_busy", 32'(bus.busy), 32'd0);
      check("arst_done", 32'(bus.done), 32'd0);
      check("arst_tready", 32'(bus.s_axis_cfg_tready), 32'd0);
      check("arst_cfg_loaded", 32'(bus.cfg_loaded), 32'd0);
      @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      pulse_start();
      expect_quiet("arst_nostart", 4);
      check("arst_still_unloaded", 32'(bus.cfg_loaded), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dds_sweep_ctrl.md
DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

Interface
REQ-001 SHALL have parameter PHASE_DW, default 16: width of phase, frequency and step words.
REQ-002 SHALL have parameter STEP_DW, default 16: width of step-count field and counter.
REQ-003 SHALL have parameter DWELL_DW, default 8: width of dwell field and counter.
REQ-004 SHALL have ports:
- clk  in  1  single clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- s_axis_cfg_start_freq  in  PHASE_DW  initial phase increment.
- s_axis_cfg_step  in  PHASE_DW  per-segment increment delta, two's complement.
- s_axis_cfg_num_steps  in  STEP_DW  segments minus 1.
- s_axis_cfg_dwell  in  DWELL_DW  samples per segment minus 1.
- s_axis_cfg_loop  in  1  repeat sweep when set.
- s_axis_cfg_tvalid  in  1  config valid.
- s_axis_cfg_tready  out  1  config accepted when tvalid && tready.
- start  in  1  single-cycle sweep start request.
- abort  in  1  single-cycle sweep stop request.
- m_axis_phase_tdata  out  PHASE_DW  phase word to the DDS s_axis_phase_tdata.
- m_axis_phase_tvalid  out  1  phase valid.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse at sweep completion.
- cfg_loaded  out  1  a config is held.

Function
REQ-005 SHALL implement FSM states IDLE, RUN, DONE.
REQ-006 SHALL drive s_axis_cfg_tready=1 in IDLE only, and 0 in RUN, in DONE and during reset.
REQ-007 SHALL latch all config fields into shadow registers on handshake and set cfg_loaded.
REQ-008 IDLE->RUN SHALL occur on start when cfg_loaded is set, or when a config handshake happens in the same cycle. The new config SHALL then be used.
REQ-009 Start with no config SHALL be ignored.
REQ-010 On entry to RUN, SHALL clear the phase accumulator, dwell counter and step counter, and load current freq = start_freq.
REQ-011 In RUN, SHALL assert m_axis_phase_tvalid every cycle, with tdata = accumulator. The accumulator SHALL then add current freq.
REQ-012 The first valid sample SHALL appear in the cycle after start and SHALL be 0.
REQ-013 The dwell counter SHALL count 0..dwell.
- At dwell: counter wraps to 0, current freq += step, step counter increments.
REQ-014 When the dwell counter equals dwell and the step counter equals num_steps, the current sample SHALL be the last.
- Total samples = (num_steps+1)*(dwell+1).
REQ-015 After the last sample with loop=0: RUN->DONE.
- DONE: tvalid=0, done=1 for one cycle, then IDLE.
REQ-016 After the last sample with loop=1: SHALL stay in RUN and re-initialise per REQ-010 with no gap cycle. done SHALL not pulse.
REQ-017 All phase and frequency arithmetic SHALL wrap modulo 2^PHASE_DW; no saturation.
REQ-018 abort in RUN or DONE SHALL force IDLE next cycle, with tvalid=0 from that cycle and no done pulse.
REQ-019 abort and start in the same IDLE cycle: abort wins, stay in IDLE. A config handshake in that cycle is still accepted.
REQ-020 start in RUN or DONE SHALL be ignored.
REQ-021 cfg_loaded SHALL remain set after a sweep; the same config may be restarted.

Reset
REQ-022 While reset_n=0, all of the following SHALL be 0:
- FSM state (IDLE), accumulator, counters, shadow registers, cfg_loaded
- m_axis_phase_tdata, m_axis_phase_tvalid, busy, done, s_axis_cfg_tready
REQ-023 Reset asserted mid-sweep SHALL terminate the sweep immediately without a done pulse. After release, a new config is required.

Configuration
REQ-024 Macro DDS_SWEEP_LOOP_EN SHALL control loop support.
- Defined: s_axis_cfg_loop is latched and honoured per REQ-016.
- Undefined: s_axis_cfg_loop is ignored and every sweep is one-shot per REQ-015.

Verification
REQ-025 Basic sweep: cfg start_freq=0x0100, step=0x0010, num_steps=2, dwell=1, loop=0; start.
- Required: 6 valid samples 0x0000, 0x0100, 0x0200, 0x0310, 0x0420, 0x0540; then done=1 for one cycle, tvalid=0, tready=1.
REQ-026 Loop (macro defined): same cfg with loop=1.
- Required: after 0x0540, the next cycle outputs 0x0000 then 0x0100, with no done pulse and busy held 1.
- Macro undefined: behaves as REQ-025.
REQ-027 Abort: cfg as REQ-025; assert abort on the 3rd valid sample.
- Required: tvalid=0 from the next cycle, no done pulse, tready=1.
REQ-028 Wrap and negative step: start_freq=0xF000, step=0xF000, num_steps=1, dwell=1.
- Required samples: 0x0000, 0xF000, 0xE000, 0xC000.
REQ-029 Handshake edges:
- start before any cfg: no output.
- cfg_tvalid during RUN: not accepted (tready=0).
- start and cfg handshake in the same IDLE cycle: the sweep uses the new config.
- start and abort in the same IDLE cycle: no sweep.
REQ-030 Async reset: drop reset_n mid-sweep between clock edges.
- Required: all outputs 0 immediately, cfg_loaded=0, start after release ignored until a new config.
